// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: start-up, +4 advance, stall hold,
// branch redirect with squash cycles, halt, and an accepted-instruction count.
module fetch_ctrl #(
  parameter int                XLEN         = 64,
  parameter logic [XLEN-1:0]   RESET_PC     = '0,
  parameter int                IMEM_WORDS   = 256,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_cur,
  output logic            fetch_valid,
  output logic            halted,
  output logic            err,
  output logic [31:0]     inst_count,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(IMEM_WORDS) << 2;
  localparam logic [XLEN-1:0] LAST_PC   = MEM_BYTES - XLEN'(4);
  localparam logic [2:0]      FLUSH_INI = 3'(FLUSH_CYCLES);

  // Valid/ready contract: an instruction at pc_cur is consumed only when
  // fetch_valid is high and no stall, redirect or halt is requested that cycle.
  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q;
  logic [2:0]        flush_cnt, flush_d;
  logic              err_set;
  logic              accept;
  logic [XLEN-1:0]   tgt;

  always_comb begin
    state_d     = state_q;
    pc_next     = pc_q;
    flush_d     = flush_cnt;
    err_set     = 1'b0;
    fetch_valid = 1'b0;
    // Low address bits of the redirect are dropped rather than faulted.
    tgt         = branch_target & ~XLEN'(3);
    unique case (state_q)
      S_IDLE: begin
        if (halt_req)   state_d = S_HALT;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        fetch_valid = 1'b1;
        if (halt_req) begin
          state_d = S_HALT;
        end else if (branch_taken) begin
          if (tgt >= MEM_BYTES) begin
            err_set = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_next = tgt;
            flush_d = FLUSH_INI;
            state_d = S_FLUSH;
          end
        end else if (stall) begin
          state_d = S_RUN;
        end else if (pc_q == LAST_PC) begin
          state_d = S_HALT;
        end else begin
          pc_next = pc_q + XLEN'(4);
        end
      end
      S_FLUSH: begin
        flush_d = flush_cnt - 3'd1;
        if (halt_req)               state_d = S_HALT;
        else if (flush_cnt == 3'd1) state_d = S_RUN;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = fetch_valid & ~stall & ~branch_taken & ~halt_req;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      flush_cnt  <= 3'd0;
      err        <= 1'b0;
      inst_count <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_next;
      flush_cnt  <= flush_d;
      err        <= err | err_set;
      if (accept) inst_count <= inst_count + 32'd1;
    end
  end

  assign pc_cur    = pc_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances (1 and 3 squash cycles) share stimulus and
// are compared every cycle against a behavioural model of the fetch sequencer.
module tb_fetch_ctrl;

  localparam int          N        = 2;
  localparam int          MEM      = 1024;
  localparam logic [63:0] LAST     = 64'd1020;
  localparam int          P_IDLE   = 0;
  localparam int          P_RUN    = 1;
  localparam int          P_SQUASH = 2;
  localparam int          P_STOP   = 3;

  logic        Clk = 1'b0;
  logic        reset, start, stall, branch_taken, halt_req;
  logic [63:0] branch_target;

  logic [63:0] pc_next    [N];
  logic [63:0] pc_cur     [N];
  logic        fetch_valid[N];
  logic        halted     [N];
  logic        err        [N];
  logic [31:0] inst_count [N];
  logic [1:0]  dbg_state  [N];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: one record per instance.
  int          m_phase[N];
  logic [63:0] m_pc   [N];
  int          m_left [N];
  bit          m_err  [N];
  logic [31:0] m_cnt  [N];
  int          m_squash[N] = '{1, 3};

  always #5 Clk = ~Clk;

  fetch_ctrl #(.XLEN(64), .RESET_PC(64'd0), .IMEM_WORDS(256), .FLUSH_CYCLES(1)) dut0 (
    .Clk(Clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .pc_next(pc_next[0]), .pc_cur(pc_cur[0]), .fetch_valid(fetch_valid[0]),
    .halted(halted[0]), .err(err[0]), .inst_count(inst_count[0]), .dbg_state(dbg_state[0])
  );

  fetch_ctrl #(.XLEN(64), .RESET_PC(64'd0), .IMEM_WORDS(256), .FLUSH_CYCLES(3)) dut1 (
    .Clk(Clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .pc_next(pc_next[1]), .pc_cur(pc_cur[1]), .fetch_valid(fetch_valid[1]),
    .halted(halted[1]), .err(err[1]), .inst_count(inst_count[1]), .dbg_state(dbg_state[1])
  );

  task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s[dut%0d] observed=0x%0h expected=0x%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = P_IDLE; m_pc[i] = 64'd0; m_left[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // Check current outputs, then advance the model by one clock with the applied inputs.
  task automatic step(input bit rst, input bit st, input bit stl, input bit br,
                      input logic [63:0] tgt, input bit hr);
    logic [63:0] t, npc;
    reset = rst; start = st; stall = stl; branch_taken = br; branch_target = tgt; halt_req = hr;
    #2;
    t = tgt & ~64'd3;
    for (int i = 0; i < N; i++) begin
      chk("fetch_valid", i, 64'(fetch_valid[i]), 64'(m_phase[i] == P_RUN));
      chk("halted",      i, 64'(halted[i]),      64'(m_phase[i] == P_STOP));
      chk("pc_cur",      i, pc_cur[i],           m_pc[i]);
      chk("err",         i, 64'(err[i]),         64'(m_err[i]));
      chk("inst_count",  i, 64'(inst_count[i]),  64'(m_cnt[i]));
      npc = m_pc[i];
      case (m_phase[i])
        P_IDLE: begin
          if (hr) m_phase[i] = P_STOP;
          else if (st) m_phase[i] = P_RUN;
        end
        P_RUN: begin
          if (hr) m_phase[i] = P_STOP;
          else if (br) begin
            if (t >= 64'(MEM)) begin m_err[i] = 1; m_phase[i] = P_STOP; end
            else begin npc = t; m_left[i] = m_squash[i]; m_phase[i] = P_SQUASH; end
          end else if (!stl) begin
            m_cnt[i] = m_cnt[i] + 1;
            if (m_pc[i] == LAST) m_phase[i] = P_STOP;
            else npc = m_pc[i] + 64'd4;
          end
        end
        P_SQUASH: begin
          if (hr) m_phase[i] = P_STOP;
          else begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) m_phase[i] = P_RUN;
          end
        end
        default: ;
      endcase
      if (!rst) chk("pc_next", i, pc_next[i], npc);
      m_pc[i] = npc;
    end
    if (rst) model_reset();
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 64'd0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 64'd0, 0);
  endtask

  initial begin
    bit          r, s, st, b, h;
    logic [63:0] tg;
    reset = 1; start = 0; stall = 0; branch_taken = 0; branch_target = '0; halt_req = 0;
    @(posedge Clk); #1;
    model_reset();

    // Start-up and sequential advance
    step(0, 1, 0, 0, 64'd0, 0);
    idle(2);
    // Stall at pc 8 for three cycles
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 64'd0, 0);
    idle(2);
    chk("plan1_count", 0, 64'(inst_count[0]), 64'd4);
    chk("plan1_pc",    0, pc_cur[0], 64'd16);
    // Redirect to 0x22 (low bits dropped) and watch the squash window
    step(0, 0, 0, 1, 64'h22, 0);
    step(0, 0, 0, 1, 64'h80, 0);
    idle(5);
    chk("redir_pc", 1, pc_cur[1], 64'h2c);
    // Out-of-range redirect: error and halt, start ignored afterwards
    step(0, 0, 0, 1, 64'h400, 0);
    step(0, 1, 0, 0, 64'd0, 0);
    step(0, 1, 1, 1, 64'h10, 0);
    chk("oor_err", 0, 64'(err[0]), 64'd1);
    do_reset();
    // halt > branch > stall in the same cycle
    step(0, 1, 0, 0, 64'd0, 0);
    idle(1);
    step(0, 0, 1, 1, 64'h40, 1);
    idle(2);
    do_reset();
    // Run off the end of memory
    step(0, 1, 0, 0, 64'd0, 0);
    step(0, 0, 0, 1, 64'h3f0, 0);
    idle(10);
    chk("end_pc", 0, pc_cur[0], LAST);
    do_reset();
    // Reset in the middle of a squash window, and halt during squash
    step(0, 1, 0, 0, 64'd0, 0);
    step(0, 0, 0, 1, 64'h100, 0);
    step(0, 0, 1, 0, 64'd0, 0);
    do_reset();
    chk("rst_count", 1, 64'(inst_count[1]), 64'd0);
    step(0, 1, 0, 0, 64'd0, 0);
    step(0, 0, 0, 1, 64'h104, 0);
    step(0, 0, 0, 0, 64'd0, 1);
    idle(2);
    do_reset();

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) == 0) ||
           ((m_phase[0] == P_STOP || m_phase[1] == P_STOP) && $urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 4) == 0);
      b  = ($urandom_range(0, 9) == 0);
      h  = ($urandom_range(0, 79) == 0);
      tg = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 4095)) : 64'($urandom_range(0, 1023));
      if ($urandom_range(0, 63) == 0) tg = {$urandom, $urandom};
      step(r, s, st, b, tg, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
